// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, types and helpers for the FFT output reorder block.
//   NBITS  : bits per real/imag part (S6.15)
//   N      : FFT length, LOG2N its log2
//   NWORDS : input/output cycles per frame (four samples per cycle)
//   KW     : width of a word counter (0..NWORDS-1)
//   CW     : complex word width {re,im}
//   bitrev : reverse the low 'width' bits of an index
package fft_out_reorder_pkg;

  localparam int NBITS  = 21;
  localparam int N      = 128;
  localparam int LOG2N  = 7;
  localparam int LANES  = 4;
  localparam int NWORDS = N / LANES;
  localparam int KW     = LOG2N - 2;
  localparam int CW     = 2 * NBITS;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Bits at or above 'width' come back as zero.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v,
                                              input int width);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      if (b < width) r[b] = v[width-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-word frame buffer of the ping-pong pair.
//   clk   : clock
//   we    : write all four lanes this cycle
//   widx  : per-lane natural sample index to write
//   wdata : per-lane complex word
//   rword : word number k; reads natural indices 4k..4k+3
//   rdata : the four words 4k+0..4k+3 (combinational)
// Contents are not reset; a bank is only read after it has been completely
// written, so stale words are never observed.
module fft_reorder_bank
  import fft_out_reorder_pkg::*;
(
  input  logic                             clk,
  input  logic                             we,
  input  logic [LANES-1:0][LOG2N-1:0]      widx,
  input  logic [LANES-1:0][CW-1:0]         wdata,
  input  logic [KW-1:0]                    rword,
  output logic [LANES-1:0][CW-1:0]         rdata
);

  logic [CW-1:0] mem [N];

  // The four lane indices within one input cycle are always distinct
  // (bit-reversal of four distinct values), so the writes never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem[widx[l]] <= wdata[l];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < LANES; j++) begin
      rdata[j] = mem[{rword, j[1:0]}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Output end of the parallel-4 128-point FFT: converts each bit-reversed frame
// into natural order, four samples per cycle, with ping-pong buffering so that
// back-to-back frames stream out without gaps.
//   clk, rst            : clock, asynchronous active-high reset
//   fftIn0_up/_down,
//   fftIn1_up/_down     : lanes 0..3 of the input, {re,im}
//   in_enable           : the four lanes are valid this cycle
//   reoOut0..3          : natural-order samples X[4k+0..3]
//   o_enable            : reoOut0..3 carry word k of the current frame
//   o_sof               : high with k=0 of each output frame
// Handshake: valid-only. in_enable qualifies the input lanes; there is no
// backpressure in either direction. o_enable qualifies the outputs, which hold
// their previous values while it is low.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] fftIn0_up,
  input  logic [CW-1:0] fftIn0_down,
  input  logic [CW-1:0] fftIn1_up,
  input  logic [CW-1:0] fftIn1_down,
  input  logic          in_enable,
  output logic [CW-1:0] reoOut0,
  output logic [CW-1:0] reoOut1,
  output logic [CW-1:0] reoOut2,
  output logic [CW-1:0] reoOut3,
  output logic          o_enable,
  output logic          o_sof
);

  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  // Write side
  logic [KW-1:0] wc;
  logic          wr_bank;
  logic          wc_last;

  // Bank status and read side
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          rd_bank;
  rd_state_e     state;
  logic [KW-1:0] k;
  logic          emit;
  logic          last_word;

  logic [LANES-1:0][LOG2N-1:0] widx;
  logic [LANES-1:0][CW-1:0]    wdata;
  logic [LANES-1:0][CW-1:0]    rdata0;
  logic [LANES-1:0][CW-1:0]    rdata1;
  logic [LANES-1:0][CW-1:0]    rsel;

  assign wdata[0] = fftIn0_up;
  assign wdata[1] = fftIn0_down;
  assign wdata[2] = fftIn1_up;
  assign wdata[3] = fftIn1_down;

  // Lane l at count wc carries sample bitrev(4*wc+l); store it at that index.
  always_comb begin
    widx = '0;
    for (int l = 0; l < LANES; l++) begin
      widx[l] = bitrev({wc, l[1:0]}, LOG2N);
    end
  end

  assign wc_last = in_enable && (wc == K_LAST);

  fft_reorder_bank u_bank0 (
    .clk   (clk),
    .we    (in_enable && !wr_bank),
    .widx  (widx),
    .wdata (wdata),
    .rword (k),
    .rdata (rdata0)
  );

  fft_reorder_bank u_bank1 (
    .clk   (clk),
    .we    (in_enable && wr_bank),
    .widx  (widx),
    .wdata (wdata),
    .rword (k),
    .rdata (rdata1)
  );

  assign rsel = rd_bank ? rdata1 : rdata0;

  // A word is registered out this edge either when IDLE finds the oldest
  // bank full (k is 0 there) or on every READ cycle.
  assign emit      = (state == RD_READ) || full[rd_bank];
  assign last_word = emit && (k == K_LAST);

  // The reader only ever clears rd_bank and the writer only ever sets
  // wr_bank; when both happen on one edge they address different banks.
  always_comb begin
    full_nxt = full;
    if (last_word) full_nxt[rd_bank] = 1'b0;
    if (wc_last)   full_nxt[wr_bank] = 1'b1;
  end

  // Write counter and bank select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc      <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (in_enable) begin
        wc <= wc + 1'b1;
        if (wc_last) wr_bank <= ~wr_bank;
      end
    end
  end

  // Read FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD_IDLE;
      k        <= '0;
      rd_bank  <= 1'b0;
      reoOut0  <= '0;
      reoOut1  <= '0;
      reoOut2  <= '0;
      reoOut3  <= '0;
      o_enable <= 1'b0;
      o_sof    <= 1'b0;
    end else begin
      if (emit) begin
        reoOut0  <= rsel[0];
        reoOut1  <= rsel[1];
        reoOut2  <= rsel[2];
        reoOut3  <= rsel[3];
        o_enable <= 1'b1;
        o_sof    <= (k == '0);
        if (last_word) begin
          k       <= '0;
          rd_bank <= ~rd_bank;
          // Chain straight into the other bank if it is already waiting.
          state   <= full[~rd_bank] ? RD_READ : RD_IDLE;
        end else begin
          k       <= k + 1'b1;
          state   <= RD_READ;
        end
      end else begin
        o_enable <= 1'b0;
        o_sof    <= 1'b0;
        state    <= RD_IDLE;
      end
    end
  end

endmodule
